// File: rtl/strand_select_stage_pkg.sv
// Shared definitions for the strand select stage: strand count, id width
// and the per-strand scheduling states.
package strand_select_stage_pkg;

  localparam int NUM_STRANDS = 4;
  localparam int STRAND_ID_W = 2;

  typedef enum logic [1:0] {
    STRAND_READY         = 2'd0,
    STRAND_SUSPENDED     = 2'd1,
    STRAND_ROLLBACK_WAIT = 2'd2
  } strand_state_t;

endpackage

// File: rtl/strand_select_stage_rr_arbiter4.sv
// Four-way round-robin arbiter; the registered pointer remembers the last
// granted requester so the search starts one past it.
module rr_arbiter4
  import strand_select_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [NUM_STRANDS-1:0] req,
  output logic [NUM_STRANDS-1:0] grant
);

  logic [STRAND_ID_W-1:0] last_q;
  logic [STRAND_ID_W-1:0] pick;
  logic [STRAND_ID_W-1:0] idx;
  logic                   found;

  // Offset NUM_STRANDS wraps back onto last_q, so it is checked last.
  always_comb begin
    grant = '0;
    found = 1'b0;
    pick  = last_q;
    idx   = '0;
    for (int i = 1; i <= NUM_STRANDS; i++) begin
      idx = last_q + STRAND_ID_W'(i);
      if (enable && !found && req[idx]) begin
        grant[idx] = 1'b1;
        pick       = idx;
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= STRAND_ID_W'(NUM_STRANDS - 1);
    end else if (found) begin
      last_q <= pick;
    end
  end

endmodule

// File: rtl/strand_select_stage.sv
// Picks one eligible strand per cycle, tracks each strand's suspend and
// rollback status, and registers the chosen instruction for the next stage.
module strand_select_stage
  import strand_select_stage_pkg::*;
#(
  parameter int ROLLBACK_WAIT_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_STRANDS-1:0]       instruction_valid_i,
  input  logic [32*NUM_STRANDS-1:0]    instruction_i,
  input  logic [32*NUM_STRANDS-1:0]    pc_i,
  output logic [NUM_STRANDS-1:0]       instruction_request_o,
  input  logic [NUM_STRANDS-1:0]       strand_enable_i,
  input  logic [NUM_STRANDS-1:0]       suspend_strand_i,
  input  logic [NUM_STRANDS-1:0]       resume_strand_i,
  input  logic [NUM_STRANDS-1:0]       rollback_strand_i,
  input  logic                         stall_i,
  output logic                         valid_o,
  output logic [31:0]                  instruction_o,
  output logic [31:0]                  pc_o,
  output logic [STRAND_ID_W-1:0]       strand_id_o
);

  localparam int CNT_W = (ROLLBACK_WAIT_CYCLES > 1) ? $clog2(ROLLBACK_WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ROLLBACK_WAIT_CYCLES);

  strand_state_t          state_q [NUM_STRANDS];
  strand_state_t          state_d [NUM_STRANDS];
  logic [CNT_W-1:0]       cnt_q   [NUM_STRANDS];
  logic [CNT_W-1:0]       cnt_d   [NUM_STRANDS];
  logic [NUM_STRANDS-1:0] eligible;
  logic [NUM_STRANDS-1:0] grant;
  logic [STRAND_ID_W-1:0] grant_idx;
  logic                   grant_any;
  logic [31:0]            instr_lane [NUM_STRANDS];
  logic [31:0]            pc_lane    [NUM_STRANDS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_STRANDS; i++) begin
        state_q[i] <= STRAND_READY;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_STRANDS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Rollback beats resume beats suspend; a counter at 0 is also treated as
  // expired so a zero wait parameter cannot strand a thread forever.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_STRANDS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (rollback_strand_i[i]) begin
        state_d[i] = STRAND_ROLLBACK_WAIT;
        cnt_d[i]   = CNT_LOAD;
      end else if (resume_strand_i[i] && state_q[i] == STRAND_SUSPENDED) begin
        state_d[i] = STRAND_READY;
      end else if (suspend_strand_i[i] && state_q[i] == STRAND_READY) begin
        state_d[i] = STRAND_SUSPENDED;
      end else if (state_q[i] == STRAND_ROLLBACK_WAIT) begin
        if (cnt_q[i] <= CNT_W'(1)) begin
          state_d[i] = STRAND_READY;
          cnt_d[i]   = '0;
        end else begin
          cnt_d[i] = cnt_q[i] - CNT_W'(1);
        end
      end
      eligible[i] = (state_q[i] == STRAND_READY) && strand_enable_i[i] &&
                    instruction_valid_i[i] && !rollback_strand_i[i] &&
                    !suspend_strand_i[i];
    end
  end

  rr_arbiter4 u_arbiter (
    .clk    (clk),
    .reset  (reset),
    .enable (!stall_i && !reset),
    .req    (eligible),
    .grant  (grant)
  );

  assign instruction_request_o = grant;
  assign grant_any             = |grant;

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_STRANDS; i++) begin
      instr_lane[i] = instruction_i[32*i +: 32];
      pc_lane[i]    = pc_i[32*i +: 32];
      if (grant[i]) begin
        grant_idx = STRAND_ID_W'(i);
      end
    end
  end

  // A stalled output is still killed if its own strand rolls back.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_o       <= 1'b0;
      instruction_o <= '0;
      pc_o          <= '0;
      strand_id_o   <= '0;
    end else if (!stall_i) begin
      if (grant_any) begin
        valid_o       <= 1'b1;
        instruction_o <= instr_lane[grant_idx];
        pc_o          <= pc_lane[grant_idx];
        strand_id_o   <= grant_idx;
      end else begin
        valid_o <= 1'b0;
      end
    end else if (valid_o && rollback_strand_i[strand_id_o]) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_strand_select_stage.sv
// Table-driven bench for strand_select_stage: per-cycle request checks plus
// a queue of expected registered outputs compared one cycle later.
module tb_strand_select_stage;
  import strand_select_stage_pkg::*;

  typedef struct packed {
    logic       rst;
    logic [3:0] valid;
    logic [3:0] enable;
    logic [3:0] suspend;
    logic [3:0] resume;
    logic [3:0] rollback;
    logic       stall;
    logic [3:0] exp_req;
  } vec_t;

  typedef struct packed {
    logic        chk_data;
    logic        valid;
    logic [1:0]  id;
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   instruction_valid_i;
  logic [127:0] instruction_i;
  logic [127:0] pc_i;
  logic [3:0]   instruction_request_o;
  logic [3:0]   strand_enable_i;
  logic [3:0]   suspend_strand_i;
  logic [3:0]   resume_strand_i;
  logic [3:0]   rollback_strand_i;
  logic         stall_i;
  logic         valid_o;
  logic [31:0]  instruction_o;
  logic [31:0]  pc_o;
  logic [1:0]   strand_id_o;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t vecs[$];
  exp_t exp_q[$];

  logic        m_valid = 1'b0;
  logic [1:0]  m_id = '0;
  logic [31:0] m_instr = '0;
  logic [31:0] m_pc = '0;

  strand_select_stage #(.ROLLBACK_WAIT_CYCLES(2)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .instruction_valid_i   (instruction_valid_i),
    .instruction_i         (instruction_i),
    .pc_i                  (pc_i),
    .instruction_request_o (instruction_request_o),
    .strand_enable_i       (strand_enable_i),
    .suspend_strand_i      (suspend_strand_i),
    .resume_strand_i       (resume_strand_i),
    .rollback_strand_i     (rollback_strand_i),
    .stall_i               (stall_i),
    .valid_o               (valid_o),
    .instruction_o         (instruction_o),
    .pc_o                  (pc_o),
    .strand_id_o           (strand_id_o)
  );

  always #5 clk = ~clk;

  function automatic vec_t v(input logic rst, input logic [3:0] valid, input logic [3:0] enable,
                             input logic [3:0] suspend, input logic [3:0] resume,
                             input logic [3:0] rollback, input logic stall, input logic [3:0] exp_req);
    vec_t r;
    r.rst = rst; r.valid = valid; r.enable = enable; r.suspend = suspend;
    r.resume = resume; r.rollback = rollback; r.stall = stall; r.exp_req = exp_req;
    return r;
  endfunction

  function automatic logic [31:0] instrOf(input int n, input int s);
    return {8'hC0 + 8'(n), 8'h00, 16'(s)};
  endfunction

  function automatic logic [31:0] pcOf(input int n);
    return 32'h100 + 32'(n) * 32'h40;
  endfunction

  function automatic logic [1:0] idxOf(input logic [3:0] oh);
    logic [1:0] r = '0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
    return r;
  endfunction

  task automatic cmp(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s step %0d: got %h, expected %h", name, step, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t vc, input int s);
    reset               = vc.rst;
    instruction_valid_i = vc.valid;
    strand_enable_i     = vc.enable;
    suspend_strand_i    = vc.suspend;
    resume_strand_i     = vc.resume;
    rollback_strand_i   = vc.rollback;
    stall_i             = vc.stall;
    for (int n = 0; n < 4; n++) begin
      instruction_i[32*n +: 32] = instrOf(n, s);
      pc_i[32*n +: 32]          = pcOf(n);
    end
  endtask

  task automatic checkOutput(input int s);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("[TB] FAIL scoreboard step %0d: got empty queue, expected an entry", s);
    end else begin
      e = exp_q.pop_front();
      cmp("valid_o", s, 32'(valid_o), 32'(e.valid));
      if (e.chk_data) begin
        cmp("strand_id_o", s, 32'(strand_id_o), 32'(e.id));
        cmp("instruction_o", s, instruction_o, e.instr);
        cmp("pc_o", s, pc_o, e.pc);
      end
    end
  endtask

  localparam logic [3:0] F = 4'hF;
  localparam logic [3:0] Z = 4'h0;

  initial begin
    //                 rst valid  en   susp   res    rb    stall exp_req
    vecs.push_back(v(1, F, F, Z, Z, Z, 0, Z));          // 0 reset
    vecs.push_back(v(1, F, F, Z, Z, F, 0, Z));          // 1 reset beats rollback
    vecs.push_back(v(0, F, F, Z, Z, Z, 0, 4'b0001));    // 2 round robin 0..3,0
    vecs.push_back(v(0, F, F, Z, Z, Z, 0, 4'b0010));
    vecs.push_back(v(0, F, F, Z, Z, Z, 0, 4'b0100));
    vecs.push_back(v(0, F, F, Z, Z, Z, 0, 4'b1000));
    vecs.push_back(v(0, F, F, Z, Z, Z, 0, 4'b0001));
    vecs.push_back(v(0, F, F, 4'b0010, Z, Z, 0, 4'b0100)); // 7 suspend strand 1
    vecs.push_back(v(0, F, F, Z, Z, Z, 0, 4'b1000));
    vecs.push_back(v(0, F, F, Z, Z, Z, 0, 4'b0001));
    vecs.push_back(v(0, F, F, Z, Z, Z, 0, 4'b0100));
    vecs.push_back(v(0, F, F, Z, 4'b0010, Z, 0, 4'b1000)); // 11 resume strand 1
    vecs.push_back(v(0, F, F, Z, Z, Z, 0, 4'b0001));
    vecs.push_back(v(0, F, F, Z, Z, Z, 0, 4'b0010));
    vecs.push_back(v(0, 4'b0001, F, Z, Z, Z, 0, 4'b0001)); // 14 strand 0, pc 0x100
    vecs.push_back(v(0, F, F, Z, Z, Z, 1, Z));          // 15 stall x3
    vecs.push_back(v(0, F, F, Z, Z, Z, 1, Z));
    vecs.push_back(v(0, F, F, Z, Z, Z, 1, Z));
    vecs.push_back(v(0, F, F, Z, Z, Z, 0, 4'b0010));
    vecs.push_back(v(0, F, F, Z, Z, Z, 0, 4'b0100));    // 19 strand 2 shown next
    vecs.push_back(v(0, F, F, Z, Z, 4'b0100, 1, Z));    // 20 rollback shown strand under stall
    vecs.push_back(v(0, 4'b0100, F, Z, Z, Z, 0, Z));    // 21 strand 2 waiting
    vecs.push_back(v(0, 4'b0100, F, Z, Z, Z, 0, Z));
    vecs.push_back(v(0, 4'b0100, F, Z, Z, Z, 0, 4'b0100)); // 23 eligible again
    vecs.push_back(v(0, F, F, Z, Z, 4'b0100, 0, 4'b1000));
    vecs.push_back(v(0, F, F, 4'b1000, Z, Z, 0, 4'b0001)); // 25 suspend strand 3
    vecs.push_back(v(0, 4'b1000, F, 4'b1000, 4'b1000, Z, 0, Z)); // 26 suspend+resume
    vecs.push_back(v(0, 4'b1000, F, Z, Z, Z, 0, 4'b1000));
    vecs.push_back(v(0, 4'b1000, F, Z, 4'b1000, 4'b1000, 0, Z)); // 28 rollback+resume
    vecs.push_back(v(0, 4'b1000, F, Z, Z, Z, 0, Z));
    vecs.push_back(v(0, 4'b1000, F, Z, Z, Z, 0, Z));
    vecs.push_back(v(0, 4'b1000, F, Z, Z, Z, 0, 4'b1000));
    vecs.push_back(v(0, F, 4'b1110, 4'b0100, Z, Z, 0, 4'b0010)); // 32 enable mask
    vecs.push_back(v(1, F, F, Z, Z, Z, 0, Z));          // 33 mid-stream reset
    vecs.push_back(v(0, F, F, Z, Z, Z, 0, 4'b0001));
    vecs.push_back(v(0, F, F, Z, Z, Z, 0, 4'b0010));
    vecs.push_back(v(0, F, F, Z, Z, Z, 0, 4'b0100));
    vecs.push_back(v(0, Z, F, Z, Z, Z, 0, Z));

    applyStimulus(vecs[0], 0);
    @(posedge clk); #1;

    for (int s = 0; s < vecs.size(); s++) begin
      vec_t vc;
      exp_t e;
      vc = vecs[s];
      applyStimulus(vc, s);
      @(negedge clk);
      cmp("instruction_request_o", s, 32'(instruction_request_o), 32'(vc.exp_req));

      if (vc.rst) begin
        m_valid = 1'b0; m_id = '0; m_instr = '0; m_pc = '0;
      end else if (!vc.stall) begin
        if (vc.exp_req != 4'h0) begin
          m_valid = 1'b1;
          m_id    = idxOf(vc.exp_req);
          m_instr = instrOf(int'(m_id), s);
          m_pc    = pcOf(int'(m_id));
        end else begin
          m_valid = 1'b0;
        end
      end else if (m_valid && vc.rollback[m_id]) begin
        m_valid = 1'b0;
      end
      e.chk_data = vc.rst || m_valid;
      e.valid    = m_valid;
      e.id       = m_id;
      e.instr    = m_instr;
      e.pc       = m_pc;
      exp_q.push_back(e);

      @(posedge clk); #1;
      checkOutput(s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
